// File: rtl/alu_arb_defs_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encodings and the default
// ALU widths that the ALU instance also uses.
package alu_arb_defs;

    localparam int ALU_WORD_SIZE = 32;
    localparam int ALU_OP_SIZE   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin picker. This logic is purely combinational.
// When both requesters are valid, ptr selects the favoured one (0 means requester 0).
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Optional grant counters are enabled by defining ALU_ARBITER_STATS_EN.
module alu_arbiter
    import alu_arb_defs::*;
#(
    parameter int WORD_SIZE = ALU_WORD_SIZE,
    parameter int OP_SIZE   = ALU_OP_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WORD_SIZE-1:0] req0_data_1,
    input  logic [WORD_SIZE-1:0] req0_data_2,
    input  logic [OP_SIZE-1:0]   req0_sel,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [WORD_SIZE-1:0] rsp0_result,
    output logic                 rsp0_zero,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WORD_SIZE-1:0] req1_data_1,
    input  logic [WORD_SIZE-1:0] req1_data_2,
    input  logic [OP_SIZE-1:0]   req1_sel,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [WORD_SIZE-1:0] rsp1_result,
    output logic                 rsp1_zero,

    output logic [WORD_SIZE-1:0] alu_data_1,
    output logic [WORD_SIZE-1:0] alu_data_2,
    output logic [OP_SIZE-1:0]   alu_sel,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic                 alu_zero_flag
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [15:0]          grant_cnt0,
    output logic [15:0]          grant_cnt1
`endif
);

    arb_state_t                      r_state;
    logic                            r_ptr;
    logic                            r_win;
    logic [WORD_SIZE-1:0]            r_alu_data_1;
    logic [WORD_SIZE-1:0]            r_alu_data_2;
    logic [OP_SIZE-1:0]              r_alu_sel;
    logic [1:0]                      r_rsp_valid;
    logic [1:0][WORD_SIZE-1:0]       r_rsp_result;
    logic [1:0]                      r_rsp_zero;

    logic [1:0] w_valid;
    logic [1:0] w_grant;
    logic [1:0] w_ready;
    logic [1:0] w_rsp_ready;
    logic       w_accept;

    assign w_valid     = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};

    rr_arb2 u_rr_arb2 (
        .valid (w_valid),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    // Ready is only offered from IDLE, and is held low while reset is asserted.
    assign w_ready  = (r_state == ST_IDLE && !rst) ? w_grant : 2'b00;
    assign w_accept = |w_ready;

    assign req0_ready  = w_ready[0];
    assign req1_ready  = w_ready[1];
    assign rsp0_valid  = r_rsp_valid[0];
    assign rsp1_valid  = r_rsp_valid[1];
    assign rsp0_result = r_rsp_result[0];
    assign rsp1_result = r_rsp_result[1];
    assign rsp0_zero   = r_rsp_zero[0];
    assign rsp1_zero   = r_rsp_zero[1];
    assign alu_data_1  = r_alu_data_1;
    assign alu_data_2  = r_alu_data_2;
    assign alu_sel     = r_alu_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= 1'b0;
            r_win        <= 1'b0;
            r_alu_data_1 <= '0;
            r_alu_data_2 <= '0;
            r_alu_sel    <= '0;
            r_rsp_valid  <= 2'b00;
            r_rsp_result <= '0;
            r_rsp_zero   <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_win        <= w_grant[1];
                        r_alu_data_1 <= w_grant[1] ? req1_data_1 : req0_data_1;
                        r_alu_data_2 <= w_grant[1] ? req1_data_2 : req0_data_2;
                        r_alu_sel    <= w_grant[1] ? req1_sel    : req0_sel;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // The ALU has had a full cycle on the registered operands.
                    r_rsp_result[r_win] <= alu_out;
                    r_rsp_zero[r_win]   <= alu_zero_flag;
                    r_rsp_valid[r_win]  <= 1'b1;
                    r_state             <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_ready[r_win]) begin
                        r_rsp_valid <= 2'b00;
                        r_ptr       <= ~r_win;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt0 <= 16'd0;
            r_grant_cnt1 <= 16'd0;
        end else begin
            if (w_ready[0] && r_grant_cnt0 != 16'hFFFF) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
            if (w_ready[1] && r_grant_cnt1 != 16'hFFFF) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model attached to the alu_* port.
module tb_alu_arbiter;

    localparam int W  = 32;
    localparam int OW = 4;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic [W-1:0]  req0_data_1, req0_data_2, rsp0_result;
    logic [OW-1:0] req0_sel;
    logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [W-1:0]  req1_data_1, req1_data_2, rsp1_result;
    logic [OW-1:0] req1_sel;
    logic [W-1:0]  alu_data_1, alu_data_2, alu_out;
    logic [OW-1:0] alu_sel;
    logic          alu_zero_flag;
`ifdef ALU_ARBITER_STATS_EN
    logic [15:0]   grant_cnt0, grant_cnt1;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WORD_SIZE(W), .OP_SIZE(OW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data_1(req0_data_1), .req0_data_2(req0_data_2), .req0_sel(req0_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data_1(req1_data_1), .req1_data_2(req1_data_2), .req1_sel(req1_sel),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero_flag(alu_zero_flag)
`ifdef ALU_ARBITER_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    always_comb begin
        case (alu_sel)
            OP_ADD:  alu_out = alu_data_1 + alu_data_2;
            OP_SUB:  alu_out = alu_data_1 - alu_data_2;
            OP_AND:  alu_out = alu_data_1 & alu_data_2;
            OP_OR:   alu_out = alu_data_1 | alu_data_2;
            OP_XOR:  alu_out = alu_data_1 ^ alu_data_2;
            default: alu_out = '0;
        endcase
        alu_zero_flag = (alu_out == '0);
    end

    typedef struct {
        logic       who;
        logic [3:0] sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic       z;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic who, input logic v, input logic [3:0] sel,
                         input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            req1_valid = v; req1_sel = sel; req1_data_1 = a; req1_data_2 = b;
        end else begin
            req0_valid = v; req0_sel = sel; req0_data_1 = a; req0_data_2 = b;
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int grants, last, rsp0_seen, rsp1_seen;
        vecs[0] = '{1'b0, OP_ADD, 32'd5,         32'd3,         32'd8,         1'b0};
        vecs[1] = '{1'b1, OP_SUB, 32'd7,         32'd7,         32'd0,         1'b1};
        vecs[2] = '{1'b0, OP_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
        vecs[3] = '{1'b1, OP_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1};
        vecs[4] = '{1'b0, OP_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd0,         1'b1};
        vecs[5] = '{1'b1, OP_AND, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'h00F0_0000, 1'b0};
        vecs[6] = '{1'b0, OP_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};

        // Reset state, with both requesters valid to show ready stays low.
        rst = 1'b1;
        rsp0_ready = 0; rsp1_ready = 0;
        drive(1'b0, 1'b1, OP_ADD, 32'd1, 32'd2);
        drive(1'b1, 1'b1, OP_ADD, 32'd3, 32'd4);
        repeat (2) tick();
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        chk("rst_alu_d1", alu_data_1, 0);
        chk("rst_alu_d2", alu_data_2, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_rsp_res", rsp0_result | rsp1_result, 0);
        chk("rst_rsp_zero", {rsp1_zero, rsp0_zero}, 0);
        req0_valid = 0; req1_valid = 0;
        rst = 1'b0;
        #1;

        // Single-requester operations.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].who, 1'b1, vecs[i].sel, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("v%0d_ready", i), {req1_ready, req0_ready}, vecs[i].who ? 2 : 1);
            tick();
            drive(vecs[i].who, 1'b0, vecs[i].sel, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("v%0d_alu_d1", i), alu_data_1, vecs[i].a);
            chk($sformatf("v%0d_alu_d2", i), alu_data_2, vecs[i].b);
            chk($sformatf("v%0d_alu_sel", i), alu_sel, vecs[i].sel);
            chk($sformatf("v%0d_exec_rsp", i), {rsp1_valid, rsp0_valid}, 0);
            tick();
            chk($sformatf("v%0d_rsp_valid", i), {rsp1_valid, rsp0_valid}, vecs[i].who ? 2 : 1);
            chk($sformatf("v%0d_result", i), vecs[i].who ? rsp1_result : rsp0_result, vecs[i].res);
            chk($sformatf("v%0d_zero", i), vecs[i].who ? rsp1_zero : rsp0_zero, vecs[i].z);
            chk($sformatf("v%0d_resp_ready", i), {req1_ready, req0_ready}, 0);
            if (vecs[i].who) rsp1_ready = 1; else rsp0_ready = 1;
            tick();
            rsp0_ready = 0; rsp1_ready = 0;
            #1;
            chk($sformatf("v%0d_rsp_clr", i), {rsp1_valid, rsp0_valid}, 0);
            chk($sformatf("v%0d_res_hold", i), vecs[i].who ? rsp1_result : rsp0_result, vecs[i].res);
            chk($sformatf("v%0d_alu_hold", i), alu_data_1, vecs[i].a);
        end

`ifdef ALU_ARBITER_STATS_EN
        chk("stats_cnt0", grant_cnt0, 4);
        chk("stats_cnt1", grant_cnt1, 3);
`endif

        // Contention from reset: strict alternation, 3 cycles per op.
        reset_pulse();
        drive(1'b0, 1'b1, OP_ADD, 32'd10, 32'd20);
        drive(1'b1, 1'b1, OP_SUB, 32'd100, 32'd1);
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        grants = 0; last = 0; rsp0_seen = 0; rsp1_seen = 0;
        for (int c = 0; c < 30 && grants < 4; c++) begin
            if (req0_ready || req1_ready) begin
                chk("cont_onehot", {31'd0, req0_ready & req1_ready}, 0);
                chk("cont_who", {31'd0, req1_ready}, grants % 2);
                if (grants > 0) chk("cont_gap", c - last, 3);
                last = c;
                grants++;
            end
            if (rsp0_valid) begin
                rsp0_seen++;
                chk("cont_rsp0_res", rsp0_result, 30);
                chk("cont_rsp0_excl", {31'd0, rsp1_valid}, 0);
            end
            if (rsp1_valid) begin
                rsp1_seen++;
                chk("cont_rsp1_res", rsp1_result, 99);
            end
            tick();
        end
        chk("cont_grants", grants, 4);
        chk("cont_rsp0_cnt", rsp0_seen, 2);
        chk("cont_rsp1_cnt", rsp1_seen, 1);

        // Response backpressure on requester 0.
        reset_pulse();
        drive(1'b0, 1'b1, OP_ADD, 32'd5, 32'd3);
        drive(1'b1, 1'b1, OP_ADD, 32'd1, 32'd1);
        #1;
        chk("bp_grant0", {req1_ready, req0_ready}, 1);
        tick();
        req0_valid = 0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 1);
            chk("bp_rsp0_res", rsp0_result, 8);
            chk("bp_no_grant", {req1_ready, req0_ready}, 0);
            tick();
        end
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        #1;
        chk("bp_grant1", {req1_ready, req0_ready}, 2);
        chk("bp_rsp0_clr", {31'd0, rsp0_valid}, 0);
        chk("bp_rsp0_hold", rsp0_result, 8);
        tick();
        req1_valid = 0;
        tick();
        chk("bp_rsp1_valid", {rsp1_valid, rsp0_valid}, 2);
        chk("bp_rsp1_res", rsp1_result, 2);
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;

        // Reset while in EXEC aborts the op.
        drive(1'b1, 1'b1, OP_ADD, 32'd9, 32'd9);
        #1;
        chk("re_grant", {req1_ready, req0_ready}, 2);
        tick();
        req1_valid = 0;
        chk("re_alu_d1", alu_data_1, 9);
        rst = 1'b1;
        #1;
        chk("re_alu_d1_rst", alu_data_1, 0);
        chk("re_alu_sel_rst", alu_sel, 0);
        chk("re_rsp_rst", {rsp1_valid, rsp0_valid}, 0);
        chk("re_res_rst", rsp0_result | rsp1_result, 0);
        tick();
        rst = 1'b0;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int k = 0; k < 3; k++) begin
            chk("re_no_rsp", {rsp1_valid, rsp0_valid}, 0);
            tick();
        end
        rsp0_ready = 0; rsp1_ready = 0;
        drive(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1);
        drive(1'b1, 1'b1, OP_ADD, 32'd2, 32'd2);
        #1;
        chk("re_grant0", {req1_ready, req0_ready}, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
